gpio_irq_ctrl: RTL

- Per-pin interrupt and event controller sitting above the array of GPIO input stages (sync + edge detect, clock-gated by an enable).
- Drives each input stage's enable and masks the spurious edges produced while a newly enabled stage warms up.
- Latches interrupt status per pin according to a programmable trigger type.
- Reports pending pins one at a time, round-robin, over a valid/ready event port; also drives a combined interrupt line.

---
 rtl/gpio_pkg.sv | 21 ++
 rtl/gpio_irq_ctrl_if.sv | 15 +
 rtl/gpio_rr_pick.sv | 30 +++
 rtl/gpio_irq_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared types for the GPIO interrupt/event controller and its helpers.
package gpio_pkg;

  typedef enum logic [2:0] {
    IRQ_RISE = 3'd0,
    IRQ_FALL = 3'd1,
    IRQ_BOTH = 3'd2,
    IRQ_HIGH = 3'd3,
    IRQ_LOW  = 3'd4
  } irq_type_e;

  typedef enum logic {
    EvtIdle,
    EvtOffer
  } evt_state_e;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_irq_ctrl_if.sv
// Event offer port: one pending pin index at a time over valid/ready.
interface gpio_irq_ctrl_if
  import gpio_pkg::*;
#(
  parameter int unsigned NrGpios = 32
);
  localparam int unsigned IdxW = idx_width(NrGpios);

  logic            valid;
  logic [IdxW-1:0] idx;
  logic            ready;

  modport master (output valid, output idx, input ready);
  modport slave  (input valid, input idx, output ready);
endinterface

// File: rtl/gpio_rr_pick.sv
// Combinational round-robin finder: first set bit of vec_i at or after start_i, wrapping.
module gpio_rr_pick #(
  parameter int unsigned N    = 32,
  parameter int unsigned IdxW = 5
) (
  input  logic [N-1:0]    vec_i,
  input  logic [IdxW-1:0] start_i,
  output logic            found_o,
  output logic [IdxW-1:0] idx_o
);

  always_comb begin
    int unsigned     pos;
    logic [IdxW-1:0] pos_idx;
    found_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(start_i) + k;
      if (pos >= N) pos = pos - N;
      pos_idx = pos[IdxW-1:0];
      if (!found_o && vec_i[pos_idx]) begin
        found_o = 1'b1;
        idx_o   = pos_idx;
      end
    end
  end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Per-pin interrupt latching with warm-up masking, plus a round-robin event offer FSM.
module gpio_irq_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned NrGpios      = 32,
  parameter int unsigned WarmupCycles = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NrGpios-1:0] gpio_en_i,
  input  logic [NrGpios-1:0] irq_en_i,
  input  irq_type_e          irq_type_i [NrGpios],
  input  logic [NrGpios-1:0] serial_i,
  input  logic [NrGpios-1:0] r_edge_i,
  input  logic [NrGpios-1:0] f_edge_i,
  output logic [NrGpios-1:0] in_en_o,
  input  logic               clr_valid_i,
  input  logic [NrGpios-1:0] clr_mask_i,
  output logic [NrGpios-1:0] irq_status_o,
  output logic               irq_o,
  gpio_irq_ctrl_if.master    evt
);

  localparam int unsigned     IdxW    = idx_width(NrGpios);
  localparam int unsigned     CntW    = $clog2(WarmupCycles + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NrGpios - 1);
  localparam logic [CntW-1:0] WarmMax = CntW'(WarmupCycles);

  logic [NrGpios-1:0] armed, hit, clr, status_q, status_d;
  evt_state_e         state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d, ptr_q, ptr_d, pick_idx;
  logic               pick_found, accept;

  assign in_en_o = gpio_en_i | irq_en_i;

  // Edges seen while the input stage is still filling its synchronizer are spurious.
  for (genvar i = 0; i < NrGpios; i++) begin : g_warm
    logic [CntW-1:0] cnt_q;
    always_ff @(posedge clk_i) begin
      if (rst_i || !in_en_o[i]) begin
        cnt_q <= '0;
      end else if (cnt_q != WarmMax) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
    assign armed[i] = (cnt_q == WarmMax) & irq_en_i[i];
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < NrGpios; i++) begin
      if (armed[i]) begin
        case (irq_type_i[i])
          IRQ_RISE: hit[i] = r_edge_i[i];
          IRQ_FALL: hit[i] = f_edge_i[i];
          IRQ_BOTH: hit[i] = r_edge_i[i] | f_edge_i[i];
          IRQ_HIGH: hit[i] = serial_i[i];
          IRQ_LOW:  hit[i] = ~serial_i[i];
          default:  hit[i] = 1'b0;
        endcase
      end
    end
  end

  gpio_rr_pick #(
    .N    (NrGpios),
    .IdxW (IdxW)
  ) u_rr_pick (
    .vec_i   (status_q),
    .start_i (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign accept = (state_q == EvtOffer) & evt.ready;

  always_comb begin
    clr = clr_valid_i ? clr_mask_i : '0;
    if (accept) clr[idx_q] = 1'b1;
    // Set wins over clear; a disabled interrupt never holds status.
    status_d = ((status_q & ~clr) | hit) & irq_en_i;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      EvtIdle: begin
        if (pick_found) begin
          idx_d   = pick_idx;
          state_d = EvtOffer;
        end
      end
      EvtOffer: begin
        if (evt.ready) begin
          state_d = EvtIdle;
          ptr_d   = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
        end
      end
      default: state_d = EvtIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      status_q <= '0;
      state_q  <= EvtIdle;
      idx_q    <= '0;
      ptr_q    <= '0;
    end else begin
      status_q <= status_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
    end
  end

  assign irq_status_o = status_q;
  assign irq_o        = |status_q;
  assign evt.valid    = (state_q == EvtOffer);
  assign evt.idx      = idx_q;

endmodule
